// File: rtl/core_bp_update_pkg.sv
// Shared definitions for the branch-predictor update path: entry layout and
// default sizing used by the resolution queue and its wrapper.
package core_bp_update_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_PTR_W = 2;
  localparam int DEF_CNT_W = 16;

  // Entry layout: pc[11:6], bhr[5:2], pht[1:0]
  localparam int ENTRY_W = 12;
  localparam int PC_LSB  = 6;
  localparam int PC_W    = 6;
  localparam int BHR_LSB = 2;
  localparam int BHR_W   = 4;
  localparam int PHT_LSB = 0;
  localparam int PHT_W   = 2;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [BHR_W-1:0] bhr;
    logic [PHT_W-1:0] pht;
  } bp_entry_t;

  // Direction the table predicted when this entry was fetched.
  function automatic logic predicted_taken(input bp_entry_t e);
    return e.pht[PHT_W-1];
  endfunction

endpackage

// File: rtl/core_bp_fifo.sv
// In-order queue of prediction contexts. Clear discards everything that is
// not being popped at the same edge, leaving wp aligned with the new rp.
module core_bp_fifo
  import core_bp_update_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W,
  parameter int W     = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wp_reg;
  logic [PTR_W-1:0] rp_reg;
  logic [PTR_W-1:0] rp_next;
  logic [PTR_W-1:0] wp_next;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             push_ok;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign rdata = mem[rp_reg];

  // When full, a push is only accepted because the head leaves at the same edge.
  assign push_ok = push && !clear && (!full || pop);

  always_comb begin
    rp_next    = pop ? rp_reg + PTR_ONE : rp_reg;
    wp_next    = push_ok ? wp_reg + PTR_ONE : wp_reg;
    count_next = count_reg;
    if (clear) begin
      wp_next    = rp_next;
      count_next = '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
    end else begin
      wp_reg    <= wp_next;
      rp_reg    <= rp_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp_reg] <= wdata;
    end
  end

endmodule

// File: rtl/core_bp_update.sv
// Resolution-side companion of the pattern history table: queues IF-time
// prediction context and replays it to the table when EX resolves the branch.
module core_bp_update
  import core_bp_update_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = DEF_PTR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_push,
  input  logic [5:0]       if_pc,
  input  logic [3:0]       if_bhr,
  input  logic [1:0]       if_pht,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic             update_BP,
  output logic             pred_right,
  output logic             taken,
  output logic [3:0]       BHR_in,
  output logic [5:0]       id_pc,
  output logic [1:0]       delayed_PHT,
  output logic             mispredict,
  output logic             err_underflow,
  output logic             err_overflow,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispred
);

  localparam logic [CNT_W-1:0] STAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] STAT_MAX = '1;

  bp_entry_t      wr_entry;
  bp_entry_t      rd_entry;
  logic [PTR_W:0] q_count;
  logic           pop;
  logic           pred_ok;
  logic           mispred_now;
  logic           push_req;
  logic           clear;
  logic           overflow_now;
  logic [1:0]     stat_inc;
  logic [2*CNT_W-1:0] stat_flat;

  assign wr_entry.pc  = if_pc;
  assign wr_entry.bhr = if_bhr;
  assign wr_entry.pht = if_pht;

  assign pop          = ex_resolve && !empty;
  assign pred_ok      = (predicted_taken(rd_entry) == ex_taken);
  assign mispred_now  = pop && !pred_ok;
  // Anything fetched in the same cycle as a mispredict or flush is wrong-path.
  assign push_req     = if_push && !flush && !mispred_now;
  assign clear        = flush || mispred_now;
  assign overflow_now = if_push && full && !ex_resolve;

  core_bp_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .clear (clear),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // Data outputs hold their last resolved values between update pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      update_BP   <= 1'b0;
      mispredict  <= 1'b0;
      pred_right  <= 1'b0;
      taken       <= 1'b0;
      BHR_in      <= '0;
      id_pc       <= '0;
      delayed_PHT <= '0;
    end else begin
      update_BP  <= pop;
      mispredict <= mispred_now;
      if (pop) begin
        pred_right  <= pred_ok;
        taken       <= ex_taken;
        BHR_in      <= rd_entry.bhr;
        id_pc       <= rd_entry.pc;
        delayed_PHT <= rd_entry.pht;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      if (ex_resolve && empty) begin
        err_underflow <= 1'b1;
      end
      if (overflow_now) begin
        err_overflow <= 1'b1;
      end
    end
  end

  assign stat_inc = {mispred_now, pop};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != STAT_MAX)) begin
        cnt_reg <= cnt_reg + STAT_ONE;
      end
    end

    assign stat_flat[gi*CNT_W +: CNT_W] = cnt_reg;
  end

  assign stat_branches = stat_flat[0 +: CNT_W];
  assign stat_mispred  = stat_flat[CNT_W +: CNT_W];

endmodule

// File: tb/tb_core_bp_update.sv
// Directed bench for core_bp_update: a default-width instance plus a 2-bit
// statistics instance driven by the same stimulus to exercise saturation.
module tb_core_bp_update;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_push;
  logic [5:0] if_pc;
  logic [3:0] if_bhr;
  logic [1:0] if_pht;
  logic       ex_resolve;
  logic       ex_taken;
  logic       flush;

  logic        full, empty, update_BP, pred_right, taken, mispredict;
  logic [3:0]  BHR_in;
  logic [5:0]  id_pc;
  logic [1:0]  delayed_PHT;
  logic        err_underflow, err_overflow;
  logic [15:0] stat_branches, stat_mispred;

  logic        s_full, s_empty, s_update_BP, s_pred_right, s_taken, s_mispredict;
  logic [3:0]  s_BHR_in;
  logic [5:0]  s_id_pc;
  logic [1:0]  s_delayed_PHT;
  logic        s_err_underflow, s_err_overflow;
  logic [1:0]  s_stat_branches, s_stat_mispred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_bp_update #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .if_push(if_push), .if_pc(if_pc), .if_bhr(if_bhr),
    .if_pht(if_pht), .ex_resolve(ex_resolve), .ex_taken(ex_taken), .flush(flush),
    .full(full), .empty(empty), .update_BP(update_BP), .pred_right(pred_right),
    .taken(taken), .BHR_in(BHR_in), .id_pc(id_pc), .delayed_PHT(delayed_PHT),
    .mispredict(mispredict), .err_underflow(err_underflow),
    .err_overflow(err_overflow), .stat_branches(stat_branches),
    .stat_mispred(stat_mispred)
  );

  core_bp_update #(.DEPTH(4), .PTR_W(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .if_push(if_push), .if_pc(if_pc), .if_bhr(if_bhr),
    .if_pht(if_pht), .ex_resolve(ex_resolve), .ex_taken(ex_taken), .flush(flush),
    .full(s_full), .empty(s_empty), .update_BP(s_update_BP),
    .pred_right(s_pred_right), .taken(s_taken), .BHR_in(s_BHR_in),
    .id_pc(s_id_pc), .delayed_PHT(s_delayed_PHT), .mispredict(s_mispredict),
    .err_underflow(s_err_underflow), .err_overflow(s_err_overflow),
    .stat_branches(s_stat_branches), .stat_mispred(s_stat_mispred)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, step past the edge, then release strobes.
  task automatic step(input logic p, input logic [5:0] pc, input logic [3:0] bhr,
                      input logic [1:0] pht, input logic r, input logic t,
                      input logic f);
    if_push    = p;
    if_pc      = pc;
    if_bhr     = bhr;
    if_pht     = pht;
    ex_resolve = r;
    ex_taken   = t;
    flush      = f;
    @(posedge clk);
    #1;
    $display("txn push=%0d pc=%h bhr=%h pht=%b resolve=%0d taken=%0d flush=%0d rst=%0d -> upd=%0d id_pc=%h pr=%0d mp=%0d empty=%0d full=%0d",
             p, pc, bhr, pht, r, t, f, rst, update_BP, id_pc, pred_right,
             mispredict, empty, full);
    if_push    = 1'b0;
    ex_resolve = 1'b0;
    ex_taken   = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    logic [5:0] head;
    logic [5:0] pcv;

    rst = 1'b0;
    if_push = 1'b0; if_pc = '0; if_bhr = '0; if_pht = '0;
    ex_resolve = 1'b0; ex_taken = 1'b0; flush = 1'b0;
    step(0, 6'h00, 4'h0, 2'b00, 0, 0, 0);
    step(0, 6'h00, 4'h0, 2'b00, 0, 0, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_update", update_BP, 0);
    chk("rst_errs", {err_underflow, err_overflow}, 0);
    chk("rst_stats", {stat_branches, stat_mispred}, 0);
    rst = 1'b1;

    // Single correctly predicted branch
    step(1, 6'h2A, 4'h5, 2'b10, 0, 0, 0);
    chk("t1_not_empty", empty, 0);
    step(0, 6'h00, 4'h0, 2'b00, 1, 1, 0);
    chk("t1_update", update_BP, 1);
    chk("t1_pred_right", pred_right, 1);
    chk("t1_taken", taken, 1);
    chk("t1_id_pc", id_pc, 6'h2A);
    chk("t1_bhr", BHR_in, 4'h5);
    chk("t1_pht", delayed_PHT, 2'b10);
    chk("t1_mispredict", mispredict, 0);
    chk("t1_branches", stat_branches, 1);
    chk("t1_empty", empty, 1);
    step(0, 6'h00, 4'h0, 2'b00, 0, 0, 0);
    chk("t1_pulse_end", update_BP, 0);
    chk("t1_hold_pc", id_pc, 6'h2A);

    // Mispredict kills younger entries and the same-cycle push
    step(1, 6'h01, 4'h1, 2'b11, 0, 0, 0);
    step(1, 6'h02, 4'h2, 2'b00, 0, 0, 0);
    step(1, 6'h03, 4'h3, 2'b01, 0, 0, 0);
    step(1, 6'h04, 4'h4, 2'b10, 1, 0, 0);
    chk("t2_update", update_BP, 1);
    chk("t2_pred_right", pred_right, 0);
    chk("t2_mispredict", mispredict, 1);
    chk("t2_id_pc", id_pc, 6'h01);
    chk("t2_empty", empty, 1);
    chk("t2_no_ovf", err_overflow, 0);
    chk("t2_mispred_cnt", stat_mispred, 1);
    chk("t2_branches", stat_branches, 2);
    step(0, 6'h00, 4'h0, 2'b00, 0, 0, 0);
    chk("t2_mp_pulse_end", mispredict, 0);

    // Fill, overflow, then steady-state push+resolve wrapping the pointers
    for (int k = 0; k < 4; k++) begin
      pcv = 6'h10 + 6'(k);
      step(1, pcv, pcv[3:0], pcv[1:0], 0, 0, 0);
    end
    chk("t3_full", full, 1);
    step(1, 6'h1F, 4'hF, 2'b11, 0, 0, 0);
    chk("t3_overflow", err_overflow, 1);
    chk("t3_still_full", full, 1);
    for (int k = 0; k < 8; k++) begin
      head = (k < 4) ? 6'h10 + 6'(k) : 6'h20 + 6'(k - 4);
      pcv  = 6'h20 + 6'(k);
      step(1, pcv, pcv[3:0], pcv[1:0], 1, head[1], 0);
      chk("t3_wrap_pc", id_pc, head);
      chk("t3_wrap_pht", delayed_PHT, head[1:0]);
      chk("t3_wrap_bhr", BHR_in, head[3:0]);
      chk("t3_wrap_pr", pred_right, 1);
      chk("t3_wrap_full", full, 1);
    end
    for (int k = 0; k < 4; k++) begin
      head = 6'h24 + 6'(k);
      step(0, 6'h00, 4'h0, 2'b00, 1, head[1], 0);
      chk("t3_drain_pc", id_pc, head);
    end
    chk("t3_drained", empty, 1);
    chk("t3_branches", stat_branches, 14);
    chk("t3_sat_branches", s_stat_branches, 3);
    chk("t3_sat_mispred", s_stat_mispred, 1);

    // Underflow
    step(0, 6'h00, 4'h0, 2'b00, 1, 1, 0);
    chk("t4_no_update", update_BP, 0);
    chk("t4_underflow", err_underflow, 1);
    step(0, 6'h00, 4'h0, 2'b00, 0, 0, 0);
    chk("t4_sticky", err_underflow, 1);
    chk("t4_branches", stat_branches, 14);

    // Flush with a valid, correct resolve in the same cycle
    step(1, 6'h30, 4'h6, 2'b10, 0, 0, 0);
    step(1, 6'h31, 4'h7, 2'b00, 0, 0, 0);
    step(1, 6'h32, 4'h8, 2'b11, 1, 1, 1);
    chk("t5_update", update_BP, 1);
    chk("t5_id_pc", id_pc, 6'h30);
    chk("t5_pred_right", pred_right, 1);
    chk("t5_empty", empty, 1);
    step(0, 6'h00, 4'h0, 2'b00, 1, 0, 0);
    chk("t5_late_resolve", update_BP, 0);
    chk("t5_underflow", err_underflow, 1);
    step(1, 6'h33, 4'h9, 2'b01, 0, 0, 0);
    step(0, 6'h00, 4'h0, 2'b00, 1, 0, 0);
    chk("t5_after_pc", id_pc, 6'h33);
    chk("t5_after_bhr", BHR_in, 4'h9);
    chk("t5_branches", stat_branches, 16);

    // Reset mid-operation drops the pending update
    step(1, 6'h01, 4'h1, 2'b11, 0, 0, 0);
    step(1, 6'h02, 4'h2, 2'b11, 0, 0, 0);
    step(1, 6'h03, 4'h3, 2'b11, 0, 0, 0);
    rst = 1'b0;
    step(0, 6'h00, 4'h0, 2'b00, 1, 1, 0);
    rst = 1'b1;
    chk("t6_update", update_BP, 0);
    chk("t6_empty", empty, 1);
    chk("t6_stats", {stat_branches, stat_mispred}, 0);
    chk("t6_errs", {err_underflow, err_overflow}, 0);
    chk("t6_sat_stats", {s_stat_branches, s_stat_mispred}, 0);
    for (int k = 0; k < 4; k++) begin
      pcv = 6'h08 + 6'(k);
      step(1, pcv, 4'h0, 2'b00, 0, 0, 0);
      step(0, 6'h00, 4'h0, 2'b00, 1, 0, 0);
      chk("t6_pr", pred_right, 1);
      chk("t6_pc", id_pc, pcv);
    end
    chk("t6_branches", stat_branches, 4);
    chk("t6_sat_branches", s_stat_branches, 3);
    chk("t6_mispred", stat_mispred, 0);
    chk("t6_sat_empty", s_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
